// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and constants for the simulation run controller.
//   run_state_e  - controller FSM state encoding
//   run_status_t - registered outcome flags reported to the testbench
//   INSN_*       - RV32I instruction words of interest to the controller
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_e;

    typedef struct packed {
        logic done;
        logic halted;
        logic timeout;
    } run_status_t;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_NOP    = 32'h0000_0013;

endpackage

// File: rtl/pc_stall_detector.sv
// pc_stall_detector: flags a CPU that keeps fetching the same PC.
//   clk, rst (sync, active low), enable (high while the CPU runs),
//   pc_in (fetch PC), stalled (high in the cycle the PC has been
//   observed unchanged for STALL_LIMIT consecutive samples).
// All state clears while enable is low, so the first enabled sample
// has no predecessor and can never count as a repeat.
module pc_stall_detector #(
    parameter int PC_WIDTH    = 32,
    parameter int STALL_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                stalled
);

    localparam int              CW   = $clog2(STALL_LIMIT);
    localparam logic [CW-1:0]   LAST = CW'(STALL_LIMIT - 1);

    logic [PC_WIDTH-1:0] prev_pc_q;
    logic                prev_vld_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                same;

    assign same = prev_vld_q && (pc_in == prev_pc_q);

    // Counter holds the number of consecutive repeats; saturates at LAST.
    always_comb begin
        cnt_d = '0;
        if (same) cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
    end

    assign stalled = enable && same && (cnt_d == LAST);

    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prev_pc_q  <= pc_in;
            prev_vld_q <= 1'b1;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller between the bench clock and the CPU.
//   Inputs : clk, rst (sync, active low), start (pulse), pc_in,
//            insn_valid, insn_in (retired instruction).
//   Outputs: cpu_rst (active low CPU reset), boot_pc, dump_en,
//            done/halted/timeout (sticky outcome), cycle_count and
//            retired_count (RUN-state statistics, saturating).
// Sequence: IDLE -start-> RESET (RST_CYCLES) -> RUN -> DONE -start-> RESET.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int                   PC_WIDTH    = 32,
    parameter int                   CNT_WIDTH   = 32,
    parameter int                   RST_CYCLES  = 4,
    parameter int                   MAX_CYCLES  = 128,
    parameter int                   STALL_LIMIT = 8,
    parameter logic [31:0]          HALT_INSN   = 32'h0000_0073,
    parameter logic [PC_WIDTH-1:0]  BOOT_PC     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic                 insn_valid,
    input  logic [31:0]          insn_in,
    output logic                 cpu_rst,
    output logic [PC_WIDTH-1:0]  boot_pc,
    output logic                 dump_en,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int                   RCW      = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0]       RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

    run_state_e            state_q, state_d;
    logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]  ret_q, ret_d;
    run_status_t           status_q, status_d;
    logic                  in_run;
    logic                  stalled;
    logic                  halt_hit;

    assign in_run   = (state_q == RUN);
    assign halt_hit = insn_valid && (insn_in == HALT_INSN);

    pc_stall_detector #(
        .PC_WIDTH    (PC_WIDTH),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk     (clk),
        .rst     (rst),
        .enable  (in_run),
        .pc_in   (pc_in),
        .stalled (stalled)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        status_d  = status_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    cyc_d     = '0;
                    ret_d     = '0;
                    status_d  = '0;
                end
            end
            RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = RUN;
                else                       rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            RUN: begin
                cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_WIDTH'(1);
                if (insn_valid) ret_d = (&ret_q) ? ret_q : ret_q + CNT_WIDTH'(1);
                // Halt/stall win over the budget when both land on one cycle.
                if (halt_hit || stalled) begin
                    state_d  = DONE;
                    status_d = '{done: 1'b1, halted: 1'b1, timeout: 1'b0};
                end else if (cyc_q == MAX_LAST) begin
                    state_d  = DONE;
                    status_d = '{done: 1'b1, halted: 1'b0, timeout: 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            ret_q     <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            status_q  <= status_d;
        end
    end

    // CPU runs only in RUN; it is frozen in reset everywhere else.
    assign cpu_rst       = in_run;
    assign dump_en       = in_run;
    assign boot_pc       = BOOT_PC;
    assign done          = status_q.done;
    assign halted        = status_q.halted;
    assign timeout       = status_q.timeout;
    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: scoreboard bench for sim_run_ctrl. Each run's expected
// outcome is computed from the stimulus tables by a reference model and
// queued; a monitor pops and compares when done rises.
module tb_sim_run_ctrl;
    import sim_ctrl_pkg::*;

    localparam int RSTC = 4;
    localparam int MAXC = 128;
    localparam int SL   = 8;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, insn_valid = 1'b0;
    logic [31:0] pc_in = '0, insn_in = '0;
    logic        cpu_rst, dump_en, done, halted, timeout;
    logic [31:0] boot_pc, cycle_count, retired_count;

    always #5 clk = ~clk;

    sim_run_ctrl #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .STALL_LIMIT(SL), .HALT_INSN(32'h0000_0073), .BOOT_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .insn_valid(insn_valid), .insn_in(insn_in), .cpu_rst(cpu_rst),
        .boot_pc(boot_pc), .dump_en(dump_en), .done(done), .halted(halted),
        .timeout(timeout), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit halted;
        bit tmo;
        int cycles;
        int retired;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_e;
    logic [31:0] pcs[MAXC];
    bit          vlds[MAXC];
    logic [31:0] inss[MAXC];

    // Walk the RUN cycles by the rules: retire, then halt insn or a PC seen
    // SL times in a row ends the run, else the last budget cycle times out.
    function automatic res_t model();
        res_t r;
        int   run_len;
        r = '{0, 0, 0, 0};
        run_len = 0;
        for (int k = 0; k < MAXC; k++) begin
            if (vlds[k]) r.retired++;
            run_len  = (k > 0 && pcs[k] == pcs[k-1]) ? run_len + 1 : 1;
            r.cycles = k + 1;
            if ((vlds[k] && inss[k] == INSN_ECALL) || run_len >= SL) begin
                r.halted = 1;
                return r;
            end
            if (k == MAXC - 1) begin
                r.tmo = 1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_free();
        for (int k = 0; k < MAXC; k++) begin
            pcs[k]  = 32'h100 + 32'(4 * k);
            vlds[k] = 0;
            inss[k] = INSN_NOP;
        end
    endtask

    task automatic fill_random();
        logic [31:0] p;
        int          hold;
        p    = $urandom & 32'hFFFC;
        hold = 0;
        for (int k = 0; k < MAXC; k++) begin
            if (hold > 0) hold--;
            else if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 9);
            else p = p + 32'd4;
            pcs[k]  = p;
            vlds[k] = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 99)) inside
                [0:1]:   inss[k] = INSN_ECALL;
                [2:7]:   inss[k] = INSN_EBREAK;
                [8:50]:  inss[k] = INSN_NOP;
                default: inss[k] = $urandom;
            endcase
        end
    endtask

    // One run from IDLE/DONE. start_at: RUN index for a stray start pulse.
    // abort_at: RUN index at which rst is pulled low (no outcome expected).
    task automatic do_run(input int start_at, input int abort_at);
        if (abort_at < 0) exp_q.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("entry_done", done, 0);
        chk("entry_halted", halted, 0);
        chk("entry_timeout", timeout, 0);
        chk("entry_cycle_count", cycle_count, 0);
        chk("entry_retired", retired_count, 0);
        chk("entry_cpu_rst", cpu_rst, 0);
        for (int i = 1; i < RSTC; i++) begin
            tick();
            chk("reset_hold_cpu_rst", cpu_rst, 0);
        end
        tick();
        chk("run_cpu_rst", cpu_rst, 1);
        chk("run_dump_en", dump_en, 1);
        for (int k = 0; k < MAXC; k++) begin
            pc_in      = pcs[k];
            insn_valid = vlds[k];
            insn_in    = inss[k];
            start      = (k == start_at);
            rst        = !(k == abort_at);
            tick();
            start = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                insn_valid = 1'b0;
                chk("abort_cpu_rst", cpu_rst, 0);
                chk("abort_dump_en", dump_en, 0);
                chk("abort_done", done, 0);
                chk("abort_cycle_count", cycle_count, 0);
                chk("abort_retired", retired_count, 0);
                repeat (3) tick();
                chk("abort_idle_cpu_rst", cpu_rst, 0);
                chk("abort_idle_cycle_count", cycle_count, 0);
                return;
            end
        end
        insn_valid = 1'b0;
        for (int w = 0; w < 8 && done !== 1'b1; w++) tick();
        chk("done_seen", done, 1);
        tick();
    endtask

    bit done_d = 0;
    always @(negedge clk) begin
        if (done === 1'b1 && !done_d) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done rose with no run queued @%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("halted", halted, mon_e.halted);
                chk("timeout", timeout, mon_e.tmo);
                chk("cycle_count", cycle_count, mon_e.cycles);
                chk("retired_count", retired_count, mon_e.retired);
                chk("done_dump_en", dump_en, 0);
                chk("done_cpu_rst", cpu_rst, 0);
            end
        end
        done_d = (done === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk("rst_cpu_rst", cpu_rst, 0);
        chk("rst_dump_en", dump_en, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_retired", retired_count, 0);
        chk("boot_pc", boot_pc, 0);
        rst = 1'b1;
        tick();
        chk("idle_cpu_rst", cpu_rst, 0);

        // Free-running PC, no halt: budget expires; stray start mid-run.
        fill_free();
        do_run(50, -1);

        // NOP stream, ecall as 10th retire.
        fill_free();
        for (int k = 0; k < MAXC; k++) begin
            vlds[k] = 1;
            inss[k] = (k == 9) ? INSN_ECALL : INSN_NOP;
        end
        do_run(-1, -1);

        // PC climbs for 5 cycles then self-loops at 0x14.
        fill_free();
        for (int k = 0; k < MAXC; k++) pcs[k] = (k < 5) ? 32'(4 * k) : 32'h14;
        do_run(-1, -1);

        // PC holds for 7 cycles only, then moves on.
        fill_free();
        for (int k = 0; k < 12; k++) pcs[k] = (k < 5) ? 32'(4 * k) : 32'h14;
        do_run(-1, -1);

        // Ecall on the final budget cycle.
        fill_free();
        vlds[MAXC-1] = 1;
        inss[MAXC-1] = INSN_ECALL;
        do_run(-1, -1);

        // Reset mid-run, then a clean run from IDLE.
        fill_free();
        do_run(-1, 20);
        fill_free();
        do_run(-1, -1);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            do_run(-1, -1);
        end

        // Second identical run back-to-back from DONE.
        fill_free();
        do_run(-1, -1);

        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
